// File: rtl/hub75_pkg.sv
// Shared HUB75 definitions: scan FSM encoding, default geometry and a width helper.
package hub75_pkg;

  localparam int unsigned DefaultPlanes      = 4;
  localparam int unsigned DefaultBaseCycles  = 64;
  localparam int unsigned DefaultRows        = 32;
  localparam int unsigned DefaultBlankCycles = 2;

  // Scan FSM encoding
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StShift = 3'd1;
  localparam logic [2:0] StBlank = 3'd2;
  localparam logic [2:0] StLatch = 3'd3;
  localparam logic [2:0] StShow  = 3'd4;

  // Bits needed to index 'value' items, never less than one so ports stay legal.
  function automatic int unsigned clog2_min1(input int unsigned value);
    return (value <= 32'd2) ? 32'd1 : 32'($clog2(value));
  endfunction

endpackage

// File: rtl/hub75_show_timer.sv
// Loadable down-counter for BLANK and SHOW intervals. Loading N-1 makes 'expired'
// pulse in the N-th cycle after the load cycle.
module hub75_show_timer #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic             active_q;

  // Load wins; otherwise count down while active and go idle after reaching zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      count_q  <= load_val;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (count_q == '0) begin
        active_q <= 1'b0;
      end else begin
        count_q <= count_q - WIDTH'(1);
      end
    end
  end

  assign expired = active_q && (count_q == '0);

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// HUB75 binary-coded-modulation scheduler: per row, shifts each bit-plane, blanks,
// latches and shows it for BASE_CYCLES << plane cycles; swaps buffers at frame end.
module hub75_bcm_scheduler
  import hub75_pkg::*;
#(
  parameter int unsigned PLANES       = DefaultPlanes,
  parameter int unsigned BASE_CYCLES  = DefaultBaseCycles,
  parameter int unsigned ROWS         = DefaultRows,
  parameter int unsigned BLANK_CYCLES = DefaultBlankCycles,
  localparam int unsigned PW = clog2_min1(PLANES),
  localparam int unsigned RW = clog2_min1(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          shift_start,
  input  logic          shift_done,
  output logic [PW-1:0] plane,
  output logic [RW-1:0] shift_row,
  output logic [RW-1:0] addr,
  output logic          latch,
  output logic          oe_n,
  output logic          buf_sel,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          frame_done
);

  localparam int unsigned ShowMax  = BASE_CYCLES << (PLANES - 1);
  localparam int unsigned TimerMax = (ShowMax > BLANK_CYCLES) ? ShowMax : BLANK_CYCLES;
  localparam int unsigned TW       = clog2_min1(TimerMax);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] plane_q, plane_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] addr_q;
  logic          shift_start_q, latch_q, oe_n_q, buf_sel_q, swap_ack_q;
  logic          frame_done_q, frame_done_d;
  logic          timer_load, timer_expired;
  logic [TW-1:0] timer_val;

  hub75_show_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_expired)
  );

  // Next-state, plane/row advance and timer loads for the scan sequence.
  always_comb begin
    state_d      = state_q;
    plane_d      = plane_q;
    row_d        = row_q;
    timer_load   = 1'b0;
    timer_val    = '0;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        plane_d = '0;
        row_d   = '0;
        if (enable) state_d = StShift;
      end
      StShift: begin
        // A done pulse coinciding with our own start pulse cannot be a real answer.
        if (!shift_start_q && shift_done) begin
          state_d    = StBlank;
          timer_load = 1'b1;
          timer_val  = TW'(BLANK_CYCLES - 1);
        end
      end
      StBlank: begin
        if (timer_expired) state_d = StLatch;
      end
      StLatch: begin
        state_d    = StShow;
        timer_load = 1'b1;
        timer_val  = (TW'(BASE_CYCLES) << plane_q) - TW'(1);
      end
      StShow: begin
        if (timer_expired) begin
          if (plane_q == PW'(PLANES - 1)) begin
            plane_d = '0;
            if (row_q == RW'(ROWS - 1)) begin
              row_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            plane_d = plane_q + PW'(1);
          end
          // enable is only honoured here so a plane is never cut short.
          if (enable) begin
            state_d = StShift;
          end else begin
            state_d = StIdle;
            plane_d = '0;
            row_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Scan state and panel outputs, registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      plane_q       <= '0;
      row_q         <= '0;
      addr_q        <= '0;
      shift_start_q <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      plane_q       <= plane_d;
      row_q         <= row_d;
      shift_start_q <= (state_d == StShift) && (state_q != StShift);
      latch_q       <= (state_d == StLatch);
      oe_n_q        <= (state_d != StShow);
      frame_done_q  <= frame_done_d;
      // addr moves only with latch, while OE is still off.
      if (state_d == StLatch) addr_q <= row_q;
    end
  end

  // Buffer swap, taken only in the frame_done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_sel_q  <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      swap_ack_q <= frame_done_q && swap_req;
      if (frame_done_q && swap_req) buf_sel_q <= ~buf_sel_q;
    end
  end

  assign shift_start = shift_start_q;
  assign plane       = plane_q;
  assign shift_row   = row_q;
  assign addr        = addr_q;
  assign latch       = latch_q;
  assign oe_n        = oe_n_q;
  assign buf_sel     = buf_sel_q;
  assign swap_ack    = swap_ack_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Bench for hub75_bcm_scheduler: a cycle-numbered event-schedule model predicts every
// output; stimulus mixes directed phases with $urandom delays, swaps and enable drops.
module tb_hub75_bcm_scheduler;

  localparam int unsigned P    = 2;
  localparam int unsigned BASE = 4;
  localparam int unsigned R    = 4;
  localparam int unsigned B    = 2;

  logic       clk = 1'b0;
  logic       rst, enable, shift_done, swap_req;
  logic       shift_start, latch, oe_n, buf_sel, swap_ack, frame_done;
  logic [0:0] plane;
  logic [1:0] shift_row, addr;

  always #5 clk = ~clk;

  hub75_bcm_scheduler #(
    .PLANES       (P),
    .BASE_CYCLES  (BASE),
    .ROWS         (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .shift_start (shift_start),
    .shift_done  (shift_done),
    .plane       (plane),
    .shift_row   (shift_row),
    .addr        (addr),
    .latch       (latch),
    .oe_n        (oe_n),
    .buf_sel     (buf_sel),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .frame_done  (frame_done)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit found;

  // Stimulus knobs
  bit en_knob, swap_knob, spur_knob, rand_en, rand_swap, rand_dly;
  int dly_knob;

  // Model: absolute cycle numbers of predicted events
  bit m_idle;
  int start_cyc, resp_cyc, latch_cyc, show_first, show_last, fd_cyc, ack_cyc, upd_cyc;
  int nplane, nrow, exp_plane, exp_row, exp_addr, exp_buf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle     = 1'b1;
    start_cyc  = -1000;
    resp_cyc   = -1000;
    latch_cyc  = -1000;
    show_first = -1000;
    show_last  = -1000;
    fd_cyc     = -1000;
    ack_cyc    = -1000;
    upd_cyc    = -1000;
    exp_plane  = 0;
    exp_row    = 0;
    exp_addr   = 0;
    exp_buf    = 0;
  endtask

  // Shifter model: answers shift_done 'delay' cycles after shift_start.
  task automatic schedule_start(input int c);
    int d;
    d = rand_dly ? int'($urandom_range(1, 10)) : dly_knob;
    start_cyc = c;
    resp_cyc  = c + d;
  endtask

  task automatic check_outputs();
    int in_show;
    in_show = (cyc >= show_first && cyc <= show_last) ? 1 : 0;
    chk("oe_n",        32'(oe_n),        32'(1 - in_show));
    chk("latch",       32'(latch),       32'(cyc == latch_cyc));
    chk("shift_start", 32'(shift_start), 32'(cyc == start_cyc));
    chk("frame_done",  32'(frame_done),  32'(cyc == fd_cyc));
    chk("swap_ack",    32'(swap_ack),    32'(cyc == ack_cyc));
    chk("buf_sel",     32'(buf_sel),     32'(exp_buf));
    chk("plane",       32'(plane),       32'(exp_plane));
    chk("shift_row",   32'(shift_row),   32'(exp_row));
    chk("addr",        32'(addr),        32'(exp_addr));
  endtask

  // Drive inputs for the current cycle, predict their consequences, advance one clock, check.
  task automatic step();
    int c;
    bit waiting;
    c = cyc;
    enable   = rand_en ? ($urandom_range(0, 15) != 0) : en_knob;
    swap_req = rand_swap ? 1'($urandom_range(0, 1)) : swap_knob;
    waiting  = (c > start_cyc) && (c <= resp_cyc);
    shift_done = (c == resp_cyc);
    if (spur_knob && !waiting && ($urandom_range(0, 3) == 0)) shift_done = 1'b1;

    if (m_idle && enable) begin
      m_idle = 1'b0;
      schedule_start(c + 1);
    end
    if (c == resp_cyc) begin
      latch_cyc  = c + B + 1;
      show_first = c + B + 2;
      show_last  = c + B + 1 + (BASE << exp_plane);
    end
    if (c == show_last) begin
      nplane = exp_plane + 1;
      nrow   = exp_row;
      if (nplane == P) begin
        nplane = 0;
        nrow   = exp_row + 1;
        if (nrow == R) begin
          nrow   = 0;
          fd_cyc = c + 1;
        end
      end
      if (enable) begin
        schedule_start(c + 1);
      end else begin
        m_idle = 1'b1;
        nplane = 0;
        nrow   = 0;
      end
      upd_cyc = c + 1;
    end
    if (c == fd_cyc && swap_req) ack_cyc = c + 1;

    @(posedge clk);
    #1;
    cyc++;
    if (cyc == upd_cyc) begin
      exp_plane = nplane;
      exp_row   = nrow;
    end
    if (cyc == latch_cyc) exp_addr = exp_row;
    if (cyc == ack_cyc) exp_buf = 1 - exp_buf;
    check_outputs();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    enable     = 1'b0;
    shift_done = 1'b0;
    swap_req   = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk("rst_shift_start", 32'(shift_start), 32'd0);
    chk("rst_plane",       32'(plane),       32'd0);
    chk("rst_shift_row",   32'(shift_row),   32'd0);
    chk("rst_addr",        32'(addr),        32'd0);
    chk("rst_latch",       32'(latch),       32'd0);
    chk("rst_oe_n",        32'(oe_n),        32'd1);
    chk("rst_buf_sel",     32'(buf_sel),     32'd0);
    chk("rst_swap_ack",    32'(swap_ack),    32'd0);
    chk("rst_frame_done",  32'(frame_done),  32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; shift_done = 1'b0; swap_req = 1'b0;
    en_knob = 0; swap_knob = 0; spur_knob = 0; rand_en = 0; rand_swap = 0; rand_dly = 0;
    dly_knob = 3;
    found = 0;
    model_reset();

    // Reset, then idle with enable low
    do_reset();
    repeat (20) step();

    // Plane weighting and a full frame wrap
    en_knob = 1;
    repeat (120) step();

    // Swap request held across a frame boundary
    swap_knob = 1;
    repeat (110) step();
    swap_knob = 0;

    // Enable drop during the row 2, plane 0 window
    for (int i = 0; i < 400; i++) begin
      if (oe_n === 1'b0 && shift_row === 2'd2 && plane === 1'b0) begin
        found = 1;
        break;
      end
      step();
    end
    chk("row2_plane0_window_reached", 32'(found), 32'd1);
    en_knob = 0;
    repeat (30) step();

    // Spurious shift_done and a slow shifter
    en_knob   = 1;
    spur_knob = 1;
    dly_knob  = 50;
    repeat (300) step();

    // Randomised delays, swaps and enable drops
    rand_en   = 1;
    rand_swap = 1;
    rand_dly  = 1;
    repeat (1500) step();

    // Reset in the middle of scanning
    rand_en = 0; rand_swap = 0; rand_dly = 0; spur_knob = 0;
    en_knob = 1; dly_knob = 3;
    repeat (17) step();
    do_reset();
    en_knob = 0;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_bcm_scheduler.md
# hub75_bcm_scheduler

Binary-coded-modulation (BCM) scheduler for the HUB75 LED panel. For every row it sequences the bit-planes, triggers the column shifter, and drives latch, output-enable and row address. Each plane is displayed for a binary-weighted time. It sits between the framebuffer read/shift path and the panel pins. At frame boundaries it handles double-buffer swap requests from the pixel writer.

## Interface

**Parameters**
- `PLANES`, 4: bit-planes per colour channel.
- `BASE_CYCLES`, 64: OE-on cycles for plane 0. Plane p shows for BASE_CYCLES<<p cycles.
- `ROWS`, 32: scanned rows per half-panel.
- `BLANK_CYCLES`, 2: OE-off settle cycles before each latch.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: run scanning.
- `shift_start` out 1: one-cycle pulse requesting the shifter to load row `shift_row`, plane `plane`.
- `shift_done` in 1: one-cycle pulse from the shifter; all columns have been clocked out.
- `plane` out clog2(PLANES): plane being shifted or shown.
- `shift_row` out clog2(ROWS): row being shifted.
- `addr` out clog2(ROWS): panel row address (A–E).
- `latch` out 1: panel LAT.
- `oe_n` out 1: panel OE, active-low.
- `buf_sel` out 1: framebuffer read by the shifter.
- `swap_req` in 1: writer requests buffer swap (level).
- `swap_ack` out 1: one-cycle pulse; swap performed.
- `frame_done` out 1: one-cycle pulse at the end of the last plane of the last row.

## Operation

**States:** IDLE, SHIFT, BLANK, LATCH, SHOW.

**IDLE**
- Outputs: oe_n=1, latch=0.
- plane and shift_row are held at 0.
- If enable=1, go to SHIFT.

**SHIFT**
- shift_start=1 in the first SHIFT cycle only.
- Wait for shift_done, which is sampled only in SHIFT cycles after the start cycle.
- On shift_done, go to BLANK.

**BLANK**
- oe_n=1 for exactly BLANK_CYCLES cycles, then go to LATCH.

**LATCH**
- One cycle: latch=1, oe_n=1, addr<=shift_row.
- Go to SHOW and load the show timer with (BASE_CYCLES<<plane)−1.

**SHOW**
- oe_n=0 for exactly BASE_CYCLES<<plane cycles.
- On expiry, advance:
  - If plane<PLANES−1, then plane++.
  - Else plane=0 and shift_row++.
  - If shift_row was ROWS−1, it wraps to 0 and frame_done pulses.
- Then:
  - If enable=0, go to IDLE and clear plane and shift_row.
  - Otherwise go to SHIFT.

**Swap**
- swap_req is sampled in the same cycle frame_done pulses.
- If swap_req=1, buf_sel toggles and swap_ack pulses in the following cycle.
- buf_sel never changes at any other time.

**Boundaries**
- enable falling during SHIFT, BLANK, LATCH or SHOW has no effect until the SHOW expiry. A frame is never cut mid-plane.
- shift_done outside SHIFT is ignored.
- rst in any state goes to IDLE with all counters cleared within one cycle.

## Timing

- All outputs are registered.
- Reset values: shift_start=0, plane=0, shift_row=0, addr=0, latch=0, oe_n=1, buf_sel=0, swap_ack=0, frame_done=0.
- IDLE→SHIFT: shift_start goes high 1 cycle after the first cycle with enable=1.
- shift_done at cycle t: oe_n stays 1 during t+1…t+BLANK_CYCLES, latch=1 at t+BLANK_CYCLES+1, and oe_n=0 from t+BLANK_CYCLES+2.
- oe_n is never low in the same cycle latch=1 or addr changes.
- Show counter width is clog2(BASE_CYCLES<<(PLANES−1)).
- frame_done is asserted in the cycle after the final SHOW cycle.

## Structure

- **Shared package `hub75_pkg`:** state encoding and default PLANES, ROWS and BASE_CYCLES constants, shared with the scan FSM and the shifter.
- **Sub-module `hub75_show_timer`:** loadable down-counter with a one-cycle `expired` pulse, used for both BLANK and SHOW intervals.

## Test plan

Unless a scenario says otherwise, the bench uses PLANES=2, BASE_CYCLES=4, ROWS=4, BLANK_CYCLES=2, and a shifter model that answers shift_done 3 cycles after shift_start.

1. **Reset/idle:** rst then enable=0 for 20 cycles → oe_n=1, latch=0, shift_start=0, all counters 0.
2. **Plane weighting:** enable=1 → per row, oe_n low for exactly 4 cycles with plane=0, then 8 cycles with plane=1. Exactly one latch pulse precedes each window.
3. **Row/frame wrap:** run one frame → addr steps 0,1,2,3 across 8 SHOW windows. frame_done pulses once, and shift_row returns to 0.
4. **Swap:** hold swap_req=1 mid-frame → buf_sel stays 0 until frame_done, then becomes 1, with swap_ack a single pulse in the next cycle.
5. **Enable drop:** deassert enable during SHOW of row 2, plane 0 → the window completes its full 4 cycles, then IDLE with counters 0. No further shift_start.
6. **Spurious/late shift_done:** pulse shift_done during SHOW → ignored. Delay shift_done by 50 cycles → BLANK waits, and oe_n stays 1 throughout SHIFT.
